// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM arbiter: FSM states, bus word types, port count.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic [23:0] addr_t;
  typedef logic [31:0] data_t;

  localparam int NPORT = 2;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: two level-held request/address pairs and
// their ack/data/error returns. The requester is the master, the arbiter the slave.
interface rom_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err0;
  logic          err1;

  modport master (
    output req0, req1, addr0, addr1,
    input  ack0, ack1, rdata0, rdata1, err0, err1
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    output ack0, ack1, rdata0, rdata1, err0, err1
  );
endinterface

// File: rtl/rom_arb_rr.sv
// Two-way round-robin grant. The pointer names the preferred port when both request;
// it moves to the other port after the served port's response.
module rom_arb_rr
  import rom_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  input  logic             served_id,
  output logic             gnt_id,
  output logic             gnt_vld
);

  logic ptr_q;
  logic ptr_d;

  // Pick the requesting port; on contention the pointer decides.
  always_comb begin
    gnt_vld = |req;
    gnt_id  = (req == 2'b11) ? ptr_q : req[1];
    ptr_d   = advance ? ~served_id : ptr_q;
  end

  // Pointer register, port 0 preferred out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one Parallel_ROM between two requesters with round-robin grant and one read
// in flight. rom_addr is held for the whole read and keeps its value while idle.
// Optional feature: define ROM_ARBITER_CACHE_EN for a one-entry cache of the last good read.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int GUARD_CYC = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rstn,
  rom_arbiter_if.slave  bus,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_readyn,
  output logic          busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] TOUT_LAST  = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic          busy_q, busy_d;
  logic          rr_id, rr_vld;
  logic [AW-1:0] req_addr;
`ifdef ROM_ARBITER_CACHE_EN
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] cdata_q, cdata_d;
  logic          cvld_q, cvld_d;
`endif

  rom_arb_rr u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       ({bus.req1, bus.req0}),
    .advance   (state_q == RESP),
    .served_id (gnt_q),
    .gnt_id    (rr_id),
    .gnt_vld   (rr_vld)
  );

  assign req_addr = rr_id ? bus.addr1 : bus.addr0;

  // Next-state logic: grant, guard wait, ROM wait with timeout, then one ack pulse.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gcnt_d     = gcnt_q;
    tcnt_d     = tcnt_q;
    tout_d     = tout_q;
    rom_addr_d = rom_addr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
`ifdef ROM_ARBITER_CACHE_EN
    tag_d      = tag_q;
    cdata_d    = cdata_q;
    cvld_d     = cvld_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_vld) begin
          gnt_d  = rr_id;
          tout_d = 1'b0;
`ifdef ROM_ARBITER_CACHE_EN
          if (cvld_q && (tag_q == req_addr)) begin
            if (rr_id) rdata1_d = cdata_q;
            else       rdata0_d = cdata_q;
            state_d = RESP;
          end else begin
            rom_addr_d = req_addr;
            gcnt_d     = '0;
            state_d    = ISSUE;
          end
`else
          rom_addr_d = req_addr;
          gcnt_d     = '0;
          state_d    = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (gcnt_q >= GUARD_LAST) begin
          tcnt_d  = '0;
          state_d = WAIT;
        end else if (gcnt_q != '1) begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (!rom_readyn) begin
          if (gnt_q) rdata1_d = rom_data;
          else       rdata0_d = rom_data;
`ifdef ROM_ARBITER_CACHE_EN
          tag_d   = rom_addr_q;
          cdata_d = rom_data;
          cvld_d  = 1'b1;
`endif
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (tcnt_q >= TOUT_LAST)) begin
          if (gnt_q) rdata1_d = '0;
          else       rdata0_d = '0;
          tout_d  = 1'b1;
          state_d = RESP;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = tout_q;
        end else begin
          ack0_d = 1'b1;
          err0_d = tout_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any read without an ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      gcnt_q     <= '0;
      tcnt_q     <= '0;
      tout_q     <= 1'b0;
      rom_addr_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ROM_ARBITER_CACHE_EN
      tag_q      <= '0;
      cdata_q    <= '0;
      cvld_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gcnt_q     <= gcnt_d;
      tcnt_q     <= tcnt_d;
      tout_q     <= tout_d;
      rom_addr_q <= rom_addr_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      busy_q     <= busy_d;
`ifdef ROM_ARBITER_CACHE_EN
      tag_q      <= tag_d;
      cdata_q    <= cdata_d;
      cvld_q     <= cvld_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;

endmodule
